// File: rtl/cpu_oci_trace_capture.sv
// On-chip trace capture buffer: records non-zero trace counts into a circular RAM,
// freezes a programmable number of captures after a trigger, then drains oldest-first.
module cpu_oci_trace_capture #(
  parameter int DATA_W    = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  input  logic                       rearm,
  input  logic                       rd_req,
  output logic [CNT_W+DATA_W-1:0]    rd_data,
  output logic                       rd_valid,
  output logic                       frozen,
  output logic                       wrapped,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [15:0]                dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = CNT_W + DATA_W;

  typedef enum logic [1:0] {ARMED, POST, FROZEN} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  optr;
  logic [AW:0]    postcnt;
  logic [EW-1:0]  mem [DEPTH];
  logic           capture;
  logic           full;
  logic           do_read;
  logic           do_rearm;

  assign capture  = (dct_count != '0) && (state != FROZEN);
  assign full     = (fill == (AW+1)'(DEPTH));
  assign do_rearm = (state == FROZEN) && rearm;
  // rearm takes precedence over a simultaneous read request
  assign do_read  = (state == FROZEN) && rd_req && !rearm && (fill != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARMED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARMED: begin
        if (test_has_ended)   state_nxt = FROZEN;
        else if (test_ending) state_nxt = (POST_TRIG == 0) ? FROZEN : POST;
      end
      POST: begin
        if (test_has_ended || (capture && postcnt == (AW+1)'(1))) state_nxt = FROZEN;
      end
      FROZEN: begin
        if (rearm) state_nxt = ARMED;
      end
      default: state_nxt = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      optr     <= '0;
      postcnt  <= '0;
      fill     <= '0;
      wrapped  <= 1'b0;
      dropped  <= '0;
      frozen   <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      frozen   <= (state_nxt == FROZEN);
      rd_valid <= do_read;
      if (do_rearm) begin
        wptr    <= '0;
        optr    <= '0;
        fill    <= '0;
        wrapped <= 1'b0;
        dropped <= '0;
      end else begin
        if (capture) begin
          wptr <= wptr + 1'b1;
          if (full) begin
            optr    <= optr + 1'b1;
            wrapped <= 1'b1;
          end else begin
            fill <= fill + 1'b1;
          end
        end
        if (do_read) begin
          optr <= optr + 1'b1;
          fill <= fill - 1'b1;
        end
        if ((state == FROZEN) && (dct_count != '0) && (dropped != '1))
          dropped <= dropped + 1'b1;
        // the trigger cycle loads postcnt; only captures in POST count down
        if ((state == ARMED) && test_ending && !test_has_ended)
          postcnt <= (AW+1)'(POST_TRIG);
        else if ((state == POST) && capture)
          postcnt <= postcnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[wptr] <= {dct_count, dct_buffer};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rd_data <= '0;
    else if (do_read) rd_data <= mem[optr];
  end

endmodule

// File: tb/tb_cpu_oci_trace_capture.sv
// Bench for cpu_oci_trace_capture: directed scenarios plus random traffic checked
// against a queue-based model of the capture buffer.
module tb_cpu_oci_trace_capture;

  localparam int DATA_W    = 30;
  localparam int CNT_W     = 4;
  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 4;
  localparam int EW        = CNT_W + DATA_W;

  logic              clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [DATA_W-1:0] dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_ending, test_has_ended, rearm, rd_req;
  logic [EW-1:0]     rd_data;
  logic              rd_valid, frozen, wrapped;
  logic [4:0]        fill;
  logic [15:0]       dropped;

  logic              z_reset;
  logic [DATA_W-1:0] z_buf;
  logic [CNT_W-1:0]  z_cnt;
  logic              z_end, z_rd, z_zero;
  logic [EW-1:0]     z_rdata;
  logic              z_rv, z_frozen, z_wrapped;
  logic [4:0]        z_fill;
  logic [15:0]       z_dropped;

  cpu_oci_trace_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rearm(rearm), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .frozen(frozen), .wrapped(wrapped),
    .fill(fill), .dropped(dropped)
  );

  cpu_oci_trace_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
    .clk(clk), .reset(z_reset), .dct_buffer(z_buf), .dct_count(z_cnt),
    .test_ending(z_end), .test_has_ended(z_zero), .rearm(z_zero), .rd_req(z_rd),
    .rd_data(z_rdata), .rd_valid(z_rv), .frozen(z_frozen), .wrapped(z_wrapped),
    .fill(z_fill), .dropped(z_dropped)
  );

  int total = 0;
  int bad   = 0;

  // reference model: buffer contents as a FIFO queue of {count, data}
  logic [EW-1:0] q[$];
  bit            m_frozen, m_post, m_wrapped, m_rv;
  int            m_left, m_dropped;
  logic [EW-1:0] m_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_frozen = 0; m_post = 0; m_wrapped = 0; m_rv = 0;
    m_left = 0; m_dropped = 0; m_rd = '0;
  endtask

  task automatic model_edge();
    bit cap;
    m_rv = 0;
    cap  = (dct_count != 0);
    if (m_frozen) begin
      if (rearm) begin
        q.delete();
        m_wrapped = 0; m_dropped = 0; m_frozen = 0; m_post = 0;
      end else begin
        if (cap && m_dropped < 65535) m_dropped++;
        if (rd_req && q.size() > 0) begin
          m_rd = q.pop_front();
          m_rv = 1;
        end
      end
    end else begin
      if (cap) begin
        q.push_back({dct_count, dct_buffer});
        if (q.size() > DEPTH) begin
          void'(q.pop_front());
          m_wrapped = 1;
        end
      end
      if (test_has_ended) begin
        m_frozen = 1; m_post = 0;
      end else if (!m_post) begin
        if (test_ending) begin
          if (POST_TRIG == 0) m_frozen = 1;
          else begin m_post = 1; m_left = POST_TRIG; end
        end
      end else if (cap) begin
        m_left--;
        if (m_left == 0) begin m_frozen = 1; m_post = 0; end
      end
    end
  endtask

  task automatic check_all();
    check("frozen",   64'(frozen),   64'(m_frozen));
    check("fill",     64'(fill),     64'(q.size()));
    check("wrapped",  64'(wrapped),  64'(m_wrapped));
    check("dropped",  64'(dropped),  64'(m_dropped));
    check("rd_valid", 64'(rd_valid), 64'(m_rv));
    check("rd_data",  64'(rd_data),  64'(m_rd));
  endtask

  task automatic cyc(input logic [3:0] c, input logic [29:0] d, input bit te, input bit th,
                     input bit ra, input bit rr);
    dct_count = c; dct_buffer = d; test_ending = te; test_has_ended = th; rearm = ra; rd_req = rr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dct_count = '0; dct_buffer = '0; test_ending = 0; test_has_ended = 0; rearm = 0; rd_req = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic capture_seven();
    for (int i = 1; i <= 3; i++) cyc(4'd1, 30'(i), 0, 0, 0, 0);
    cyc(4'd0, 30'd0, 1, 0, 0, 0);
    for (int i = 4; i <= 7; i++) cyc(4'd1, 30'(i), 0, 0, 0, 0);
  endtask

  logic [EW-1:0] e;

  initial begin
    z_reset = 1'b1; z_buf = '0; z_cnt = '0; z_end = 0; z_rd = 0; z_zero = 0;
    do_reset();
    z_reset = 1'b0;

    // trigger with post-trigger window, then full drain
    capture_seven();
    check("s1_frozen", 64'(frozen), 64'd1);
    check("s1_fill",   64'(fill),   64'd7);
    cyc(4'd0, 30'd0, 0, 0, 0, 1);
    e = {4'd1, 30'd1};
    check("s1_first_rd", 64'(rd_data), 64'(e));
    for (int i = 0; i < 6; i++) cyc(4'd0, 30'd0, 0, 0, 0, 1);
    e = {4'd1, 30'd7};
    check("s1_last_rd", 64'(rd_data), 64'(e));
    cyc(4'd0, 30'd0, 0, 0, 0, 1);
    check("s1_empty_rd", 64'(rd_valid), 64'd0);

    // wrap-around
    cyc(4'd0, 30'd0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(4'd1, 30'(i), 0, 0, 0, 0);
    cyc(4'd0, 30'd0, 0, 1, 0, 0);
    check("s2_fill",    64'(fill),    64'd16);
    check("s2_wrapped", 64'(wrapped), 64'd1);
    cyc(4'd0, 30'd0, 0, 0, 0, 1);
    e = {4'd1, 30'd4};
    check("s2_first_rd", 64'(rd_data), 64'(e));

    // drops while frozen, then rearm
    for (int i = 0; i < 5; i++) cyc(4'd2, 30'(i), 0, 0, 0, 0);
    check("s3_dropped", 64'(dropped), 64'd5);
    check("s3_fill",    64'(fill),    64'd15);
    cyc(4'd0, 30'd0, 0, 0, 1, 0);
    check("s3_frozen",  64'(frozen),  64'd0);
    check("s3_rfill",   64'(fill),    64'd0);
    check("s3_rdrop",   64'(dropped), 64'd0);
    check("s3_rwrap",   64'(wrapped), 64'd0);

    // trigger and forced freeze together with a capture
    cyc(4'd1, 30'hA, 1, 1, 0, 0);
    check("s4_frozen", 64'(frozen), 64'd1);
    check("s4_fill",   64'(fill),   64'd1);
    cyc(4'd0, 30'd0, 0, 0, 0, 1);
    e = {4'd1, 30'hA};
    check("s4_rd", 64'(rd_data), 64'(e));

    // read edge cases
    cyc(4'd0, 30'd0, 0, 0, 0, 1);
    check("s5_rd_empty", 64'(rd_valid), 64'd0);
    cyc(4'd0, 30'd0, 0, 0, 1, 0);
    cyc(4'd1, 30'd9, 0, 0, 0, 0);
    cyc(4'd0, 30'd0, 0, 0, 0, 1);
    check("s5_rd_armed", 64'(rd_valid), 64'd0);
    cyc(4'd0, 30'd0, 0, 1, 0, 0);
    cyc(4'd0, 30'd0, 0, 0, 1, 1);
    check("s5_rd_rearm", 64'(rd_valid), 64'd0);
    check("s5_fill",     64'(fill),     64'd0);

    // reset in the middle of a readout
    capture_seven();
    cyc(4'd0, 30'd0, 0, 0, 0, 1);
    cyc(4'd0, 30'd0, 0, 0, 0, 1);
    do_reset();
    check("s6_rd_data", 64'(rd_data), 64'd0);
    cyc(4'd0, 30'd0, 0, 0, 0, 1);
    check("s6_no_rv", 64'(rd_valid), 64'd0);
    cyc(4'd1, 30'h33, 0, 0, 0, 0);
    check("s6_fill", 64'(fill), 64'd1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      cyc(c, 30'($urandom()), $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
    end

    // zero-length post-trigger window
    z_cnt = 4'd1; z_buf = 30'h5; z_end = 1;
    @(posedge clk); #1;
    z_cnt = '0; z_buf = '0; z_end = 0;
    check("z_frozen", 64'(z_frozen), 64'd1);
    check("z_fill",   64'(z_fill),   64'd1);
    z_rd = 1;
    @(posedge clk); #1;
    z_rd = 0;
    check("z_rv", 64'(z_rv), 64'd1);
    e = {4'd1, 30'h5};
    check("z_rd", 64'(z_rdata), 64'(e));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
